// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_pkg : op codes, FSM state encoding and widths shared by alu_seq      |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package alu_pkg;

    localparam int ALU_OPW = 4;

    localparam logic [ALU_OPW-1:0] OP_ADD   = 4'd0;
    localparam logic [ALU_OPW-1:0] OP_SUB   = 4'd1;
    localparam logic [ALU_OPW-1:0] OP_AND   = 4'd2;
    localparam logic [ALU_OPW-1:0] OP_OR    = 4'd3;
    localparam logic [ALU_OPW-1:0] OP_XOR   = 4'd4;
    localparam logic [ALU_OPW-1:0] OP_SLL   = 4'd5;
    localparam logic [ALU_OPW-1:0] OP_SRL   = 4'd6;
    localparam logic [ALU_OPW-1:0] OP_SRA   = 4'd7;
    localparam logic [ALU_OPW-1:0] OP_SLT   = 4'd8;
    localparam logic [ALU_OPW-1:0] OP_SLTU  = 4'd9;
    localparam logic [ALU_OPW-1:0] OP_PASSB = 4'd10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_RESULT = 2'd2;

    function automatic logic is_shift_op(input logic [ALU_OPW-1:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_seq_if : request/result handshake bundle between core and alu_seq    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface alu_seq_if
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) ();

    logic               in_valid;
    logic               in_ready;
    logic [ALU_OPW-1:0] op;
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    y;
    logic               zero;
    logic               lt;
    logic               ltu;
    logic               illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, zero, lt, ltu, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, zero, lt, ltu, illegal
    );

endinterface
`default_nettype wire

// File: rtl/alu_shift_step.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_shift_step : combinational shift by 0..SHIFT_STEP, left or right     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module alu_shift_step #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    localparam int AMTW      = $clog2(SHIFT_STEP + 1)
) (
    input  logic [XLEN-1:0] data_i,
    input  logic [AMTW-1:0] amt_i,
    input  logic            right_i,
    input  logic            fill_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] w_fill_mask;

    // Vacated upper bits of a right shift take the fill value.
    assign w_fill_mask = ~({XLEN{1'b1}} >> amt_i) & {XLEN{fill_i}};
    assign data_o      = right_i ? ((data_i >> amt_i) | w_fill_mask) : (data_i << amt_i);

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_seq : handshaked RV32I ALU, single-cycle ops plus iterative shifts   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);

    localparam int SHW  = $clog2(XLEN);
    localparam int AMTW = $clog2(SHIFT_STEP + 1);

    logic [1:0]      state_q;
    logic [XLEN-1:0] y_q;
    logic            zero_q;
    logic            lt_q;
    logic            ltu_q;
    logic            illegal_q;
    logic [SHW-1:0]  rem_q;
    logic            right_q;
    logic            fill_q;

    logic [XLEN:0]   w_diff;
    logic            w_zero;
    logic            w_lt;
    logic            w_ltu;
    logic [SHW-1:0]  w_shamt;
    logic            w_illegal;
    logic            w_multi_cycle;
    logic [XLEN-1:0] w_res;
    logic            w_done;
    logic [AMTW-1:0] w_amt;
    logic [XLEN-1:0] w_shifted;

    // One subtractor feeds SUB, SLT/SLTU and all three flags.
    assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};
    assign w_ltu  = w_diff[XLEN];
    assign w_zero = (w_diff[XLEN-1:0] == '0);
    assign w_lt   = (bus.a[XLEN-1] != bus.b[XLEN-1]) ? bus.a[XLEN-1] : w_ltu;

    assign w_shamt       = bus.b[SHW-1:0];
    assign w_illegal     = (bus.op > OP_PASSB);
    assign w_multi_cycle = is_shift_op(bus.op) && (w_shamt != '0);

    always_comb begin
        w_res = '0;
        case (bus.op)
            OP_ADD:   w_res = bus.a + bus.b;
            OP_SUB:   w_res = w_diff[XLEN-1:0];
            OP_AND:   w_res = bus.a & bus.b;
            OP_OR:    w_res = bus.a | bus.b;
            OP_XOR:   w_res = bus.a ^ bus.b;
            OP_SLL,
            OP_SRL,
            OP_SRA:   w_res = bus.a;
            OP_SLT:   w_res = {{(XLEN-1){1'b0}}, w_lt};
            OP_SLTU:  w_res = {{(XLEN-1){1'b0}}, w_ltu};
            OP_PASSB: w_res = bus.b;
            default:  w_res = '0;
        endcase
    end

    // Final iteration takes whatever remains, which may be less than a full step.
    assign w_done = ({1'b0, rem_q} <= (SHW+1)'(SHIFT_STEP));
    assign w_amt  = w_done ? AMTW'(rem_q) : AMTW'(SHIFT_STEP);

    alu_shift_step #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift_step (
        .data_i  (y_q),
        .amt_i   (w_amt),
        .right_i (right_q),
        .fill_i  (fill_q),
        .data_o  (w_shifted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            y_q       <= '0;
            zero_q    <= 1'b0;
            lt_q      <= 1'b0;
            ltu_q     <= 1'b0;
            illegal_q <= 1'b0;
            rem_q     <= '0;
            right_q   <= 1'b0;
            fill_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        zero_q    <= w_zero;
                        lt_q      <= w_lt;
                        ltu_q     <= w_ltu;
                        illegal_q <= w_illegal;
                        right_q   <= (bus.op != OP_SLL);
                        fill_q    <= (bus.op == OP_SRA) && bus.a[XLEN-1];
                        rem_q     <= w_shamt;
                        y_q       <= w_res;
                        state_q   <= w_multi_cycle ? ST_SHIFT : ST_RESULT;
                    end
                end
                ST_SHIFT: begin
                    // y_q doubles as the working register while shifting.
                    y_q <= w_shifted;
                    if (w_done) begin
                        rem_q   <= '0;
                        state_q <= ST_RESULT;
                    end else begin
                        rem_q <= rem_q - SHW'(SHIFT_STEP);
                    end
                end
                ST_RESULT: begin
                    if (bus.out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_RESULT);
    assign bus.y         = y_q;
    assign bus.zero      = zero_q;
    assign bus.lt        = lt_q;
    assign bus.ltu       = ltu_q;
    assign bus.illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_seq : random and directed checks of alu_seq, SHIFT_STEP 1 and 8   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_alu_seq;

    localparam int XLEN = 32;
    localparam int STEP0 = 1;
    localparam int STEP1 = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.XLEN(XLEN)) if0 ();
    alu_seq_if #(.XLEN(XLEN)) if1 ();

    assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
    assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;
    assign if0.op = op; assign if1.op = op;
    assign if0.a = a;   assign if1.a = a;
    assign if0.b = b;   assign if1.b = b;

    alu_seq #(.XLEN(XLEN), .SHIFT_STEP(STEP0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    alu_seq #(.XLEN(XLEN), .SHIFT_STEP(STEP1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    logic        in_ready_o [2];
    logic        out_valid_o[2];
    logic [31:0] y_o        [2];
    logic        zero_o     [2];
    logic        lt_o       [2];
    logic        ltu_o      [2];
    logic        illegal_o  [2];

    assign in_ready_o[0] = if0.in_ready;   assign in_ready_o[1] = if1.in_ready;
    assign out_valid_o[0] = if0.out_valid; assign out_valid_o[1] = if1.out_valid;
    assign y_o[0] = if0.y;                 assign y_o[1] = if1.y;
    assign zero_o[0] = if0.zero;           assign zero_o[1] = if1.zero;
    assign lt_o[0] = if0.lt;               assign lt_o[1] = if1.lt;
    assign ltu_o[0] = if0.ltu;             assign ltu_o[1] = if1.ltu;
    assign illegal_o[0] = if0.illegal;     assign illegal_o[1] = if1.illegal;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: RV32I semantics in plain arithmetic.
    function automatic void ref_alu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] z,
                                    output logic [31:0] y, output logic ill);
        int sh;
        sh  = int'(z % 32);
        ill = 1'b0;
        case (o)
            4'd0:  y = x + z;
            4'd1:  y = x - z;
            4'd2:  y = x & z;
            4'd3:  y = x | z;
            4'd4:  y = x ^ z;
            4'd5:  y = x << sh;
            4'd6:  y = x >> sh;
            4'd7:  y = 32'($signed(x) >>> sh);
            4'd8:  y = ($signed(x) < $signed(z)) ? 32'd1 : 32'd0;
            4'd9:  y = (x < z) ? 32'd1 : 32'd0;
            4'd10: y = z;
            default: begin y = 32'd0; ill = 1'b1; end
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] o, input logic [31:0] z, input int step);
        int sh;
        sh = int'(z % 32);
        if ((o >= 4'd5) && (o <= 4'd7) && (sh != 0)) return 1 + (sh + step - 1) / step;
        return 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [3:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                          input int hold);
        logic [31:0] ey;
        logic        eill;
        int          lat [2];
        int          elat[2];
        int          cyc;
        ref_alu(op_v, a_v, b_v, ey, eill);
        elat[0] = ref_latency(op_v, b_v, STEP0);
        elat[1] = ref_latency(op_v, b_v, STEP1);
        for (int d = 0; d < 2; d++) check($sformatf("in_ready_idle[%0d]", d), 64'(in_ready_o[d]), 64'd1);
        in_valid = 1'b1; op = op_v; a = a_v; b = b_v;
        tick();
        in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
        lat[0] = 0; lat[1] = 0; cyc = 1;
        while (1) begin
            for (int d = 0; d < 2; d++) if (lat[d] == 0 && out_valid_o[d]) lat[d] = cyc;
            if ((lat[0] != 0 && lat[1] != 0) || cyc >= 100) break;
            tick();
            cyc++;
        end
        for (int d = 0; d < 2; d++) check($sformatf("latency op%0d[%0d]", op_v, d), 64'(lat[d]), 64'(elat[d]));
        // Request raised during RESULT must be ignored.
        in_valid = 1'b1; op = 4'd0;
        for (int h = 0; h < hold; h++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                check($sformatf("hold_valid[%0d]", d), 64'(out_valid_o[d]), 64'd1);
                check($sformatf("hold_ready[%0d]", d), 64'(in_ready_o[d]), 64'd0);
                check($sformatf("hold_y[%0d]", d), 64'(y_o[d]), 64'(ey));
            end
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("y op%0d[%0d]", op_v, d), 64'(y_o[d]), 64'(ey));
            check($sformatf("zero[%0d]", d), 64'(zero_o[d]), 64'(a_v == b_v));
            check($sformatf("lt[%0d]", d), 64'(lt_o[d]), 64'($signed(a_v) < $signed(b_v)));
            check($sformatf("ltu[%0d]", d), 64'(ltu_o[d]), 64'(a_v < b_v));
            check($sformatf("illegal[%0d]", d), 64'(illegal_o[d]), 64'(eill));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("post_valid[%0d]", d), 64'(out_valid_o[d]), 64'd0);
            check($sformatf("post_ready[%0d]", d), 64'(in_ready_o[d]), 64'd1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  ro;
        rst = 1'b1;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_in_ready[%0d]", d), 64'(in_ready_o[d]), 64'd1);
            check($sformatf("rst_out_valid[%0d]", d), 64'(out_valid_o[d]), 64'd0);
            check($sformatf("rst_y[%0d]", d), 64'(y_o[d]), 64'd0);
            check($sformatf("rst_flags[%0d]", d),
                  64'({zero_o[d], lt_o[d], ltu_o[d], illegal_o[d]}), 64'd0);
        end
        rst = 1'b0;
        tick();

        run_op(4'd0,  32'hFFFF_FFFF, 32'd1,         0);
        run_op(4'd7,  32'h8000_0000, 32'd31,        0);
        run_op(4'd5,  32'd5,         32'h0000_0020, 0);
        run_op(4'd1,  32'd3,         32'd7,         4);
        run_op(4'd13, 32'd9,         32'd9,         0);
        run_op(4'd0,  32'd2,         32'd2,         0);
        run_op(4'd8,  32'h7FFF_FFFF, 32'h8000_0000, 1);
        run_op(4'd6,  32'hFFFF_FFFF, 32'd31,        0);

        // Reset during a shift aborts it without leaving a result behind.
        in_valid = 1'b1; op = 4'd6; a = 32'hF000_0000; b = 32'd20;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("abort_valid[%0d]", d), 64'(out_valid_o[d]), 64'd0);
            check($sformatf("abort_ready[%0d]", d), 64'(in_ready_o[d]), 64'd1);
            check($sformatf("abort_y[%0d]", d), 64'(y_o[d]), 64'd0);
        end
        out_ready = 1'b1;
        stale = 0;
        repeat (40) begin
            tick();
            if (out_valid_o[0] || out_valid_o[1]) stale++;
        end
        out_ready = 1'b0;
        check("abort_stale", 64'(stale), 64'd0);

        for (int i = 0; i < 80; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = ra;
                1: ra = 32'h8000_0000 | ra;
                2: rb = 32'($urandom_range(0, 3));
                default: ;
            endcase
            run_op(ro, ra, rb, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
